uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
// PURPOSE
//   Serial receive front-end of the UART path, between the uart_rx pin and the AXI-lite UART slave.
//   Synchronises the asynchronous rx line and times it with a 16x oversampling tick.
//   Rejects start-bit glitches and deframes 8N1 characters (LSB first).
//   Presents each byte on the dout/rdy/rdy_clr handshake the AXI slave already consumes.
//   Flags framing errors and overruns.
// PARAMETERS
//   CLK_HZ      50_000_000  input clock frequency in Hz
//   BAUD        115200      line rate in bit/s
//   OVERSAMPLE  16          ticks per bit; must be even and >= 8
//   DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated; 27 with the defaults. Elaboration error if DIV < 1.
// PORTS
//   clk_50_mhz  in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   rx          in   1  asynchronous serial input; idles high
//   dout        out  8  last good received byte
//   rdy         out  1  byte valid in dout; held until cleared
//   rdy_clr     in   1  consumer acknowledge; clears rdy
//   busy        out  1  frame in progress (any state other than IDLE)
//   frame_err   out  1  one-cycle pulse: stop bit sampled low
//   overrun     out  1  one-cycle pulse: good byte landed while rdy was still 1
// BEHAVIOUR
// - Reset values: dout=0, rdy=0, busy=0, frame_err=0, overrun=0. State goes to IDLE.
//   Divider, tick counter and bit counter clear. Synchroniser flops preset to 1.
//   Reset mid-frame abandons the frame silently; no flag is raised.
// - Input: 2-flop synchroniser gives rx_s. A third flop gives rx_d for edge detect.
//   fall = rx_d & ~rx_s.
// - Tick: divider counts 0..DIV-1. tick = 1 for one clk when it wraps.
//   The divider and the tick counter (tcnt) are forced to 0 on the cycle fall is accepted in IDLE.
//   This aligns sampling to the start edge.
// - FSM:
//   IDLE:  on fall -> START. busy=0.
//   START: on tick, tcnt++. When tcnt reaches OVERSAMPLE/2-1 (bit middle), sample rx_s:
//          rx_s=0 -> DATA, tcnt=0, bitcnt=0.
//          rx_s=1 -> IDLE (glitch; no flag, no output change).
//   DATA:  on tick, tcnt++. When tcnt reaches OVERSAMPLE-1, tcnt=0 and shift rx_s into sh[7] (shift right, LSB first).
//          After bitcnt=7 is sampled -> STOP; otherwise bitcnt++.
//   STOP:  on tick, tcnt++. When tcnt reaches OVERSAMPLE-1, sample rx_s, then -> IDLE:
//          1 -> dout<=sh and rdy<=1 on the next edge. overrun pulses if rdy was 1 and rdy_clr=0 that cycle.
//          0 -> frame_err pulses. dout and rdy are unchanged.
// - Returning to IDLE at stop-bit middle permits back-to-back frames.
//   After a break (line held low), no new frame starts until rx_s returns high and falls again.
// - rdy: set by a good stop; cleared by rdy_clr. If both occur in the same cycle, set wins and rdy stays 1.
//   Overwriting dout while rdy=1 is allowed; overrun reports it.
// - Latency: rdy rises 1 clk after the stop-bit middle sample.
//   From the rx falling edge that is about 9.5 bit times plus 3 clk of synchroniser and edge detect.
// - Counter widths: tcnt uses $clog2(OVERSAMPLE) bits, bitcnt 3 bits, divider $clog2(DIV) bits (minimum 1).
//   No counter wraps unintentionally.
// TESTING
//   1. Send 0xA5 8N1 at 115200 -> dout=0xA5, rdy=1 ~82.5 us after the start edge, busy low again, no flags.
//      Then rdy_clr for 1 clk -> rdy=0.
//   2. Drive rx low for 3 ticks (~1.6 us), then high -> stays in IDLE: rdy=0, dout unchanged, no flags.
//   3. Send 0x3C with the stop bit low -> frame_err pulses exactly 1 clk, rdy=0, dout keeps its old value.
//      Next valid frame is received only after rx returns high.
//   4. Send 0x11 then 0x22 back-to-back without rdy_clr -> overrun pulses once on the 2nd byte, dout=0x22, rdy=1.
//   5. Assert rdy_clr on the same cycle the 2nd byte's rdy is set -> rdy=1, dout=0x22, no overrun pulse.
//   6. Assert reset at data bit 4 of a frame, release, send 0x5A -> all outputs 0 during reset, then dout=0x5A, rdy=1.
//      No spurious byte or flag is produced.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampled 8N1 receive front-end for the UART path. It synchronises rx,
// rejects start glitches, deframes bytes onto dout/rdy/rdy_clr, and pulses frame_err/overrun.
module uart_rx_sampler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50_mhz,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCNT_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] FULL_LAST = TCNT_W'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_sampler: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
        $error("uart_rx_sampler: OVERSAMPLE must be even and at least 8");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [TCNT_W-1:0] tcnt;
    logic [2:0]        bitcnt;
    logic [7:0]        sh;
    logic              rx_meta;
    logic              rx_s;
    logic              rx_d;
    logic              fall;
    logic              tick;

    assign fall = rx_d & ~rx_s;
    assign tick = (div_cnt == DIV_LAST);

    // NOTE: every register here is assigned with <=, so all branches below read the
    // pre-edge values of rdy, sh and the counters regardless of statement order.
    always_ff @(posedge clk_50_mhz) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            tcnt      <= '0;
            bitcnt    <= '0;
            sh        <= '0;
            dout      <= '0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_d      <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);

            // A good stop bit later in this block overrides the clear: set wins.
            if (rdy_clr) rdy <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        tcnt    <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == HALF_LAST) begin
                            tcnt   <= '0;
                            bitcnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt == FULL_LAST) begin
                            tcnt <= '0;
                            sh   <= {rx_s, sh[7:1]};
                            if (bitcnt == 3'd7) state <= STOP;
                            else                bitcnt <= bitcnt + 3'd1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tcnt == FULL_LAST) begin
                            tcnt  <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (rx_s) begin
                                dout    <= sh;
                                rdy     <= 1'b1;
                                overrun <= rdy & ~rdy_clr;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
